itwiddle_stream: RTL



---
 rtl/fft_pkg.sv | 65 ++++++
 rtl/cmul_q15.sv | 70 +++++++
 rtl/itwiddle_stream.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT/IFFT datapath.
//   - Q1.15 twiddle magnitudes for the first three non-trivial angles of W16
//   - twiddle_exp(n): twiddle exponent for frame index n between radix-4 stages
//   - path_t: how a sample is rotated (untouched, exact +j, or full multiply)
//   - twiddle_coef(e): path and conjugate coefficient (cos, +sin) for exponent e
//   - rnd_sat_q15 / neg_sat16: Q1.15 rounding and saturation helpers
package fft_pkg;

    localparam logic signed [15:0] COS_1_16 = 16'sd30274;
    localparam logic signed [15:0] COS_2_16 = 16'sd23170;
    localparam logic signed [15:0] COS_3_16 = 16'sd12540;

    typedef enum logic [1:0] {
        BYPASS,
        ROT_J,
        CMUL
    } path_t;

    typedef struct packed {
        logic signed [15:0] cos_v;
        logic signed [15:0] sin_v;
        path_t              path;
    } coef_t;

    // e = (n / 4) * (n % 4); only 0,1,2,3,4,6,9 can occur for n in 0..15.
    function automatic logic [3:0] twiddle_exp(input logic [3:0] n);
        return {2'b00, n[3:2]} * {2'b00, n[1:0]};
    endfunction

    // Inverse direction: the sine term is positive (conjugate of the forward twiddle).
    function automatic coef_t twiddle_coef(input logic [3:0] e);
        coef_t c;
        c.cos_v = '0;
        c.sin_v = '0;
        c.path  = BYPASS;
        case (e)
            4'd1: begin c.cos_v = COS_1_16;  c.sin_v = COS_3_16;  c.path = CMUL; end
            4'd2: begin c.cos_v = COS_2_16;  c.sin_v = COS_2_16;  c.path = CMUL; end
            4'd3: begin c.cos_v = COS_3_16;  c.sin_v = COS_1_16;  c.path = CMUL; end
            4'd4: begin c.path = ROT_J; end
            4'd6: begin c.cos_v = -COS_2_16; c.sin_v = COS_2_16;  c.path = CMUL; end
            4'd9: begin c.cos_v = -COS_1_16; c.sin_v = -COS_3_16; c.path = CMUL; end
            default: c.path = BYPASS;
        endcase
        return c;
    endfunction

    // Round half-up at bit 14, drop 15 fraction bits, clamp to Q1.15.
    function automatic logic signed [15:0] rnd_sat_q15(input logic signed [32:0] x);
        logic signed [32:0] r;
        r = (x + 33'sd16384) >>> 15;
        if (r > 33'sd32767)
            return 16'sh7FFF;
        else if (r < -33'sd32768)
            return 16'sh8000;
        else
            return r[15:0];
    endfunction

    // Negation where -(-1.0) clamps to the largest positive value.
    function automatic logic signed [15:0] neg_sat16(input logic signed [15:0] x);
        return (x == 16'sh8000) ? 16'sh7FFF : -x;
    endfunction

endpackage

// File: rtl/cmul_q15.sv
// Two-stage registered Q1.15 complex multiply y = a * w.
//   clk, rst      : clock, synchronous active-high reset
//   en            : advance both stages (hold when low)
//   a_re, a_im    : sample operand, Q1.15
//   w_re, w_im    : coefficient operand, Q1.15
//   y_re, y_im    : rounded, saturated product, two enabled cycles after the operands
// Stage 1 registers the four 32-bit partial products, stage 2 forms the
// 33-bit sums, rounds and saturates.
module cmul_q15
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [15:0] a_re,
    input  logic signed [15:0] a_im,
    input  logic signed [15:0] w_re,
    input  logic signed [15:0] w_im,
    output logic signed [15:0] y_re,
    output logic signed [15:0] y_im
);

    // Partial product k = op_a[k] * op_b[k]:
    //   0: re*c   1: im*s   2: re*s   3: im*c
    logic signed [15:0] op_a [4];
    logic signed [15:0] op_b [4];

    always_comb begin
        op_a[0] = a_re;  op_b[0] = w_re;
        op_a[1] = a_im;  op_b[1] = w_im;
        op_a[2] = a_re;  op_b[2] = w_im;
        op_a[3] = a_im;  op_b[3] = w_re;
    end

    logic [3:0][31:0] prod_next;
    logic [3:0][31:0] prod_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_prod
            assign prod_next[gi] = 32'(op_a[gi]) * 32'(op_b[gi]);
        end
    endgenerate

    logic signed [32:0] sum_re_next;
    logic signed [32:0] sum_im_next;
    logic signed [15:0] y_re_reg;
    logic signed [15:0] y_im_reg;

    always_comb begin
        sum_re_next = 33'($signed(prod_reg[0])) - 33'($signed(prod_reg[1]));
        sum_im_next = 33'($signed(prod_reg[2])) + 33'($signed(prod_reg[3]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_reg <= '0;
            y_re_reg <= '0;
            y_im_reg <= '0;
        end else if (en) begin
            prod_reg <= prod_next;
            y_re_reg <= rnd_sat_q15(sum_re_next);
            y_im_reg <= rnd_sat_q15(sum_im_next);
        end
    end

    assign y_re = y_re_reg;
    assign y_im = y_im_reg;

endmodule

// File: rtl/itwiddle_stream.sv
// Streaming inverse-twiddle stage between the two radix-4 stages of the
// 16-point IFFT. Sample n of each frame is rotated by exp(+j*2*pi*e/16),
// e = (n/4)*(n%4), through a fixed 3-stage pipeline.
//   clk, rst             : clock, synchronous active-high reset
//   s_valid/s_ready      : input handshake; s_re/s_im Q1.15 sample, s_last marks n=15
//   m_valid/m_ready      : output handshake; m_re/m_im Q1.15 sample, m_last marks n=15
//   frame_err            : one-cycle pulse when s_last disagrees with the local index
// The whole pipeline advances on one enable, so the e=0 bypass and the exact
// +j rotation travel alongside the multiplier and latency never varies.
module itwiddle_stream
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [15:0] s_re,
    input  logic signed [15:0] s_im,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic signed [15:0] m_re,
    output logic signed [15:0] m_im,
    output logic               m_last,
    output logic               frame_err
);

    logic       en;
    logic       accept;
    logic [3:0] n_reg;
    logic [3:0] exp_next;
    coef_t      coef_next;
    logic       last_next;

    // Stage 1: sample, coefficient, path
    logic               v1_reg, last1_reg;
    path_t              path1_reg;
    logic signed [15:0] re1_reg, im1_reg, cos1_reg, sin1_reg;
    // Stage 2/3: side-band for the non-multiplier paths
    logic               v2_reg, last2_reg, v3_reg, last3_reg;
    path_t              path2_reg, path3_reg;
    logic signed [15:0] byp2_re_reg, byp2_im_reg, byp3_re_reg, byp3_im_reg;
    logic signed [15:0] cmul_re, cmul_im;
    logic               frame_err_reg;

    // A stalled output freezes every stage, so the input must stall too.
    assign en     = m_ready | ~m_valid;
    assign accept = s_valid & en;

    always_comb begin
        exp_next  = twiddle_exp(n_reg);
        coef_next = twiddle_coef(exp_next);
        last_next = (n_reg == 4'd15);
    end

    // The index never resynchronises to s_last; a mismatch is only reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg         <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= accept & (s_last != last_next);
            if (accept)
                n_reg <= n_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg      <= 1'b0;
            last1_reg   <= 1'b0;
            path1_reg   <= BYPASS;
            re1_reg     <= '0;
            im1_reg     <= '0;
            cos1_reg    <= '0;
            sin1_reg    <= '0;
            v2_reg      <= 1'b0;
            last2_reg   <= 1'b0;
            path2_reg   <= BYPASS;
            byp2_re_reg <= '0;
            byp2_im_reg <= '0;
            v3_reg      <= 1'b0;
            last3_reg   <= 1'b0;
            path3_reg   <= BYPASS;
            byp3_re_reg <= '0;
            byp3_im_reg <= '0;
        end else if (en) begin
            v1_reg      <= s_valid;
            last1_reg   <= s_valid & last_next;
            path1_reg   <= coef_next.path;
            re1_reg     <= s_re;
            im1_reg     <= s_im;
            cos1_reg    <= coef_next.cos_v;
            sin1_reg    <= coef_next.sin_v;

            v2_reg      <= v1_reg;
            last2_reg   <= last1_reg;
            path2_reg   <= path1_reg;
            // Multiply by +j: (re, im) -> (-im, re)
            byp2_re_reg <= (path1_reg == ROT_J) ? neg_sat16(im1_reg) : re1_reg;
            byp2_im_reg <= (path1_reg == ROT_J) ? re1_reg : im1_reg;

            v3_reg      <= v2_reg;
            last3_reg   <= last2_reg;
            path3_reg   <= path2_reg;
            byp3_re_reg <= byp2_re_reg;
            byp3_im_reg <= byp2_im_reg;
        end
    end

    cmul_q15 u_cmul (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .a_re (re1_reg),
        .a_im (im1_reg),
        .w_re (cos1_reg),
        .w_im (sin1_reg),
        .y_re (cmul_re),
        .y_im (cmul_im)
    );

    // Both candidates are registers aligned to stage 3; path3 picks one.
    assign s_ready   = en;
    assign m_valid   = v3_reg;
    assign m_last    = last3_reg;
    assign m_re      = (path3_reg == CMUL) ? cmul_re : byp3_re_reg;
    assign m_im      = (path3_reg == CMUL) ? cmul_im : byp3_im_reg;
    assign frame_err = frame_err_reg;

endmodule
